// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fpu
//  Description : Types shared across the single-precision FP datapath: the
//                normalized pre-rounding result, rounding mode encodings and
//                the IEEE status flag set {nv,dz,of,uf,nx}.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu;

   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } fpu_round_mode_t;

   // mantissa[23] is the hidden bit; guard = {G, R, S}
   typedef struct packed {
      logic            sign;
      logic [7:0]      exponent;
      logic [23:0]     mantissa;
      logic [2:0]      guard;
      logic            nan;
      logic            inf;
      logic            zero;
      fpu_round_mode_t mode;
   } fpu_result_t;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fpu_status_flags_t;

endpackage : fpu
`default_nettype wire

// File: rtl/fpu_round_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fpu_round
//  Description : Stage register layout and the two pure functions of the
//                rounding pipe: decide (increment/inexact/tiny) and apply
//                (mantissa increment, overflow and special-case packing).
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_round;
   import fpu::*;

   typedef struct packed {
      logic            sign;
      logic [7:0]      exponent;
      logic [23:0]     mantissa;
      logic            inc;
      logic            nx0;
      logic            tiny;
      logic            nan;
      logic            inf;
      fpu_round_mode_t mode;
   } fpu_round_s1_t;

   typedef struct packed {
      logic [31:0]       value;
      fpu_status_flags_t flags;
   } fpu_round_out_t;

   function automatic fpu_round_s1_t fpu_round_decide(input fpu_result_t r);
      fpu_round_s1_t s;
      logic          g;
      logic          rs;
      logic          nx0;
      logic          inc;
      g   = r.guard[2];
      rs  = |r.guard[1:0];
      nx0 = |r.guard;
      case (r.mode)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = nx0 & r.sign;
         RM_RUP:  inc = nx0 & ~r.sign;
         RM_RMM:  inc = g;
         default: inc = g & (rs | r.mantissa[0]);  // RNE and unused encodings
      endcase
      s.sign     = r.sign;
      s.exponent = r.exponent;
      s.mantissa = r.mantissa;
      s.inc      = inc;
      s.nx0      = nx0;
      s.tiny     = (r.exponent == 8'h00);  // tininess judged before rounding
      s.nan      = r.nan;
      s.inf      = r.inf;
      s.mode     = r.mode;
      return s;
   endfunction

   function automatic fpu_round_out_t fpu_round_apply(input fpu_round_s1_t s,
                                                      input logic [31:0] canon_nan);
      fpu_round_out_t o;
      logic [24:0]    sum;
      logic [23:0]    m;
      logic [8:0]     exp9;
      logic [31:0]    inf_v;
      logic [31:0]    max_v;
      sum   = {1'b0, s.mantissa} + {24'd0, s.inc};
      m     = sum[24] ? 24'h800000 : sum[23:0];
      // 9-bit exponent so a carry out of 254/255 is seen rather than wrapped
      exp9  = {1'b0, s.exponent} + {8'd0, sum[24]};
      // Subnormal rounded up into the hidden bit becomes the smallest normal
      if (exp9 == 9'd0 && m[23]) begin
         exp9 = 9'd1;
      end
      inf_v = {s.sign, 8'hFF, 23'h000000};
      max_v = {s.sign, 8'hFE, 23'h7FFFFF};
      o     = '0;
      if (s.nan) begin
         o.value = canon_nan;
      end else if (s.inf) begin
         o.value = inf_v;
      end else if (exp9 >= 9'd255) begin
         o.flags.of = 1'b1;
         o.flags.nx = 1'b1;
         case (s.mode)
            RM_RTZ:  o.value = max_v;
            RM_RDN:  o.value = s.sign ? inf_v : max_v;
            RM_RUP:  o.value = s.sign ? max_v : inf_v;
            default: o.value = inf_v;
         endcase
      end else if (m == 24'd0) begin
         o.value    = {s.sign, 31'd0};
         o.flags.nx = s.nx0;
      end else begin
         o.value    = {s.sign, exp9[7:0], m[22:0]};
         o.flags.nx = s.nx0;
         o.flags.uf = s.tiny & s.nx0;
      end
      return o;
   endfunction

endpackage : fpu_round
`default_nettype wire

// File: rtl/fpu_round_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_round_pipe
//  Description : Final rounding/packing stage of the binary32 datapath.
//                Stage 1 decides rounding, stage 2 applies it and holds the
//                packed result. Valid/ready on both sides, full throughput,
//                an opaque tag travels with each beat.
//  Ports       : clk, rst (sync, active high), flush (kills in-flight beats)
//                in_valid/in_ready/in_result/in_tag   upstream beat
//                out_valid/out_ready/out_value/out_flags/out_tag  result beat
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_round_pipe
   import fpu::*;
   import fpu_round::*;
#(
   parameter int          TAG_WIDTH     = 5,
   parameter logic [31:0] CANONICAL_NAN = 32'h7FC00000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  fpu_result_t          in_result,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_value,
   output logic [4:0]           out_flags,
   output logic [TAG_WIDTH-1:0] out_tag
);

   logic                 s1_valid_q, s1_valid_d;
   fpu_round_s1_t        s1_data_q,  s1_data_d;
   logic [TAG_WIDTH-1:0] s1_tag_q,   s1_tag_d;
   logic                 s2_valid_q, s2_valid_d;
   fpu_round_out_t       s2_data_q,  s2_data_d;
   logic [TAG_WIDTH-1:0] s2_tag_q,   s2_tag_d;
   logic                 w_s2_adv;
   logic                 w_unused_zero;

   // The zero flag is informational; the result is derived from the fields.
   assign w_unused_zero = in_result.zero;

   assign w_s2_adv  = out_ready | ~s2_valid_q;
   assign in_ready  = ~rst & (~s1_valid_q | w_s2_adv);
   assign out_valid = s2_valid_q;
   assign out_value = s2_data_q.value;
   assign out_flags = s2_data_q.flags;
   assign out_tag   = s2_tag_q;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_tag_d   = s2_tag_q;
      if (w_s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d = fpu_round_apply(s1_data_q, CANONICAL_NAN);
            s2_tag_d  = s1_tag_q;
         end
      end
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d = fpu_round_decide(in_result);
            s1_tag_d  = in_tag;
         end
      end
      // Flush also swallows a beat accepted in the same cycle.
      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

endmodule : fpu_round_pipe
`default_nettype wire

// File: tb/tb_fpu_round_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_round_pipe
//  Description : Self-checking bench for fpu_round_pipe. Table of rounding
//                vectors streamed through a tag-ordered scoreboard, plus
//                hand-written stall and flush sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_round_pipe;
   import fpu::*;

   localparam int TW = 5;

   logic            clk;
   logic            rst;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   fpu_result_t     in_result;
   logic [TW-1:0]   in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_value;
   logic [4:0]      out_flags;
   logic [TW-1:0]   out_tag;

   fpu_round_pipe #(.TAG_WIDTH(TW), .CANONICAL_NAN(32'h7FC00000)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_result (in_result),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_value (out_value),
      .out_flags (out_flags),
      .out_tag   (out_tag)
   );

   typedef struct {
      fpu_result_t in;
      logic [31:0] val;
      logic [4:0]  flg;
   } vec_t;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [31:0]   val;
      logic [4:0]    flg;
   } sb_t;

   vec_t          vecs[$];
   sb_t           sbq[$];
   int            vectors = 0;
   int            errors  = 0;
   logic [TW-1:0] next_tag = '0;
   logic [31:0]   exp_val;
   logic [4:0]    exp_flg;
   bit            rr_en = 1'b0;
   bit            ready_force = 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic fpu_result_t mk(input logic s, input logic [7:0] e, input logic [23:0] m,
                                      input logic [2:0] g, input logic [2:0] md,
                                      input logic n, input logic i, input logic z);
      fpu_result_t r;
      r.sign = s; r.exponent = e; r.mantissa = m; r.guard = g;
      r.nan = n; r.inf = i; r.zero = z; r.mode = fpu_round_mode_t'(md);
      return r;
   endfunction

   task automatic add(input fpu_result_t r, input logic [31:0] v, input logic [4:0] f);
      vec_t x;
      x.in = r; x.val = v; x.flg = f;
      vecs.push_back(x);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %08h, expected %08h", name, act, req);
      end
   endtask

   // Offers one beat; a flush in the offer cycle consumes it (it is discarded).
   task automatic send(input vec_t v);
      bit acc;
      int n;
      in_valid  = 1'b1;
      in_result = v.in;
      in_tag    = next_tag;
      exp_val   = v.val;
      exp_flg   = v.flg;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready || flush;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         vectors++;
         errors++;
         $display("FAIL send_timeout: tag %0d not accepted in 200 cycles, expected acceptance", next_tag);
      end
      next_tag = next_tag + 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      rr_en       = 1'b0;
      ready_force = 1'b1;
      while ((sbq.size() != 0 || out_valid) && n < 500) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      vectors++;
      if (sbq.size() != 0 || out_valid) begin
         errors++;
         $display("FAIL drain: %0d beats outstanding, out_valid %0b, expected 0 and 0", sbq.size(), out_valid);
      end
   endtask

   // Downstream ready: random backpressure or a forced level.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rr_en ? ($urandom_range(0, 3) != 0) : ready_force;
      end
   end

   // Scoreboard and stability monitor.
   initial begin : monitor
      bit  held_v;
      sb_t held;
      sb_t e;
      held_v = 1'b0;
      held   = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held_v = 1'b0;
         end else begin
            if (held_v) begin
               vectors++;
               if (!out_valid || {out_tag, out_value, out_flags} != held) begin
                  errors++;
                  $display("FAIL stall_stable: got v%0b tag %0d %08h/%05b, expected v1 tag %0d %08h/%05b",
                           out_valid, out_tag, out_value, out_flags, held.tag, held.val, held.flg);
               end
            end
            held_v = out_valid && !out_ready && !flush;
            held   = {out_tag, out_value, out_flags};
            if (flush) begin
               sbq.delete();
            end else begin
               if (out_valid && out_ready) begin
                  vectors++;
                  if (sbq.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_beat: got tag %0d %08h, expected no beat", out_tag, out_value);
                  end else begin
                     e = sbq.pop_front();
                     if ({out_tag, out_value, out_flags} != e) begin
                        errors++;
                        $display("FAIL result: got tag %0d %08h flags %05b, expected tag %0d %08h flags %05b",
                                 out_tag, out_value, out_flags, e.tag, e.val, e.flg);
                     end
                  end
               end
               if (in_valid && in_ready) begin
                  sbq.push_back({in_tag, exp_val, exp_flg});
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [TW-1:0] t0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_result = '0;
      in_tag    = '0;
      exp_val   = '0;
      exp_flg   = '0;

      //    sign exp    mant       grd  mode nan inf zero     value         flags
      add(mk(0, 8'h7F, 24'h800001, 3'b100, 3'd0, 0, 0, 0), 32'h3F800002, 5'b00001);
      add(mk(0, 8'h7F, 24'h800000, 3'b100, 3'd0, 0, 0, 0), 32'h3F800000, 5'b00001);
      add(mk(0, 8'h7F, 24'hFFFFFF, 3'b110, 3'd0, 0, 0, 0), 32'h40000000, 5'b00001);
      add(mk(0, 8'h7F, 24'hFFFFFF, 3'b110, 3'd1, 0, 0, 0), 32'h3FFFFFFF, 5'b00001);
      add(mk(0, 8'hFE, 24'hFFFFFF, 3'b100, 3'd0, 0, 0, 0), 32'h7F800000, 5'b00101);
      add(mk(1, 8'hFF, 24'h800000, 3'b000, 3'd1, 0, 0, 0), 32'hFF7FFFFF, 5'b00101);
      add(mk(0, 8'h00, 24'h7FFFFF, 3'b111, 3'd3, 0, 0, 0), 32'h00800000, 5'b00011);
      add(mk(0, 8'h00, 24'h7FFFFF, 3'b111, 3'd1, 0, 0, 0), 32'h007FFFFF, 5'b00011);
      add(mk(0, 8'h00, 24'h000000, 3'b000, 3'd0, 1, 0, 0), 32'h7FC00000, 5'b00000);
      add(mk(1, 8'h12, 24'h345678, 3'b101, 3'd0, 0, 1, 0), 32'hFF800000, 5'b00000);
      add(mk(1, 8'h00, 24'h000000, 3'b000, 3'd0, 0, 0, 0), 32'h80000000, 5'b00000);
      add(mk(0, 8'h7F, 24'h800000, 3'b100, 3'd4, 0, 0, 0), 32'h3F800001, 5'b00001);
      add(mk(1, 8'h7F, 24'h800000, 3'b001, 3'd2, 0, 0, 0), 32'hBF800001, 5'b00001);
      add(mk(0, 8'h7F, 24'h800000, 3'b001, 3'd2, 0, 0, 0), 32'h3F800000, 5'b00001);
      add(mk(0, 8'hFF, 24'h800000, 3'b000, 3'd3, 0, 0, 0), 32'h7F800000, 5'b00101);
      add(mk(1, 8'hFF, 24'h800000, 3'b000, 3'd3, 0, 0, 0), 32'hFF7FFFFF, 5'b00101);
      add(mk(0, 8'hFF, 24'h800000, 3'b000, 3'd2, 0, 0, 0), 32'h7F7FFFFF, 5'b00101);
      add(mk(1, 8'hFF, 24'h800000, 3'b000, 3'd2, 0, 0, 0), 32'hFF800000, 5'b00101);
      add(mk(0, 8'h7F, 24'h800001, 3'b100, 3'd5, 0, 0, 0), 32'h3F800002, 5'b00001);
      add(mk(0, 8'h80, 24'hC00000, 3'b000, 3'd0, 0, 0, 0), 32'h40400000, 5'b00000);
      add(mk(0, 8'h00, 24'h000010, 3'b011, 3'd0, 0, 0, 0), 32'h00000010, 5'b00011);
      add(mk(0, 8'h7F, 24'h800000, 3'b000, 3'd0, 0, 0, 1), 32'h3F800000, 5'b00000);
      add(mk(1, 8'h40, 24'h900000, 3'b111, 3'd0, 1, 1, 0), 32'h7FC00000, 5'b00000);
      add(mk(0, 8'h7F, 24'h800000, 3'b110, 3'd0, 0, 0, 0), 32'h3F800001, 5'b00001);
      add(mk(1, 8'h7F, 24'h800000, 3'b001, 3'd3, 0, 0, 0), 32'hBF800000, 5'b00001);
      add(mk(0, 8'hFE, 24'hFFFFFF, 3'b111, 3'd1, 0, 0, 0), 32'h7F7FFFFF, 5'b00001);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_value", out_value,          32'd0);
      chk("rst_out_flags", {27'd0, out_flags}, 32'd0);
      chk("rst_out_tag",   {27'd0, out_tag},   32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Table, back-to-back with full downstream readiness, then with backpressure
      @(posedge clk);
      #1;
      foreach (vecs[i]) send(vecs[i]);
      in_valid = 1'b0;
      rr_en = 1'b1;
      foreach (vecs[i]) send(vecs[i]);
      in_valid = 1'b0;
      drain();

      // Six beats with downstream stalled after the pipe fills
      ready_force = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      t0 = next_tag;
      fork
         begin
            for (int i = 0; i < 6; i++) send(vecs[i]);
            in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_out_tag",   {27'd0, out_tag},   {27'd0, t0});
            chk("stall_out_value", out_value,          vecs[0].val);
            repeat (2) @(posedge clk);
            ready_force = 1'b1;
         end
      join
      drain();

      // Flush mid-stream while stalled
      @(posedge clk);
      #1;
      fork
         begin
            for (int i = 0; i < 10; i++) send(vecs[i + 6]);
            in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            ready_force = 1'b0;
            @(posedge clk);
            #1 flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
            ready_force = 1'b1;
            @(negedge clk);
            chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
            chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
         end
      join
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule : tb_fpu_round_pipe
`default_nettype wire
